sprite_compositor: RTL and testbench

- Parametrised, multi-channel successor to the fixed single-sprite hit logic in the sprite mapper.
- Holds position and enable for NUM_SPRITES square sprites. Each write goes to a pending bank, and all pending writes are committed together at the frame boundary (vsync falling edge), so a frame never tears.
- For each VGA pixel it reports the highest-priority (lowest-index) sprite covering the pixel, plus local coordinates within that sprite for the sprite ROM lookup.
- Optionally accumulates per-frame collisions between sprite 0 (Samus) and every other sprite.

---
 rtl/sprite_compositor.sv | 169 ++++++++++++++++
 tb/tb_sprite_compositor.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_compositor.sv
// Double-buffered multi-sprite hit tester with a 2-cycle pixel pipeline and lowest-index priority.
// Optional sprite-0 collision accumulation is enabled by defining SPRITE_COLLISION_EN.
module sprite_compositor #(
  parameter int NUM_SPRITES = 8,
  parameter int COORD_W     = 10,
  parameter int SIZE_LOG2   = 4,
  parameter int IDX_W       = $clog2(NUM_SPRITES)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   wr_en,
  input  logic [IDX_W-1:0]       wr_idx,
  input  logic [COORD_W-1:0]     wr_x,
  input  logic [COORD_W-1:0]     wr_y,
  input  logic                   wr_vis,
  input  logic                   vs,
  input  logic                   pix_valid,
  input  logic [COORD_W-1:0]     DrawX,
  input  logic [COORD_W-1:0]     DrawY,
  output logic                   out_valid,
  output logic                   hit,
  output logic [IDX_W-1:0]       hit_idx,
  output logic [SIZE_LOG2-1:0]   local_x,
  output logic [SIZE_LOG2-1:0]   local_y,
  output logic [NUM_SPRITES-1:0] collision_mask
);

  localparam logic [COORD_W:0] SIDE = (COORD_W+1)'(2**SIZE_LOG2);

  logic                 pend_vis [NUM_SPRITES];
  logic [COORD_W-1:0]   pend_x   [NUM_SPRITES];
  logic [COORD_W-1:0]   pend_y   [NUM_SPRITES];
  logic                 act_vis  [NUM_SPRITES];
  logic [COORD_W-1:0]   act_x    [NUM_SPRITES];
  logic [COORD_W-1:0]   act_y    [NUM_SPRITES];

  logic vs_q;
  logic swap;
  assign swap = vs_q & ~vs;

  // Active bank takes the pre-write pending values, so a swap-cycle write waits a frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vs_q <= 1'b1;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pend_vis[i] <= 1'b0;
        pend_x[i]   <= '0;
        pend_y[i]   <= '0;
        act_vis[i]  <= 1'b0;
        act_x[i]    <= '0;
        act_y[i]    <= '0;
      end
    end else begin
      vs_q <= vs;
      if (swap) begin
        for (int i = 0; i < NUM_SPRITES; i++) begin
          act_vis[i] <= pend_vis[i];
          act_x[i]   <= pend_x[i];
          act_y[i]   <= pend_y[i];
        end
      end
      if (wr_en && (int'(wr_idx) < NUM_SPRITES)) begin
        pend_vis[wr_idx] <= wr_vis;
        pend_x[wr_idx]   <= wr_x;
        pend_y[wr_idx]   <= wr_y;
      end
    end
  end

  logic [COORD_W:0]       dx;
  logic [COORD_W:0]       dy;
  logic [NUM_SPRITES-1:0] cover_d;
  logic [NUM_SPRITES-1:0] cover_q;
  logic [SIZE_LOG2-1:0]   offx_d [NUM_SPRITES];
  logic [SIZE_LOG2-1:0]   offy_d [NUM_SPRITES];
  logic [SIZE_LOG2-1:0]   offx_q [NUM_SPRITES];
  logic [SIZE_LOG2-1:0]   offy_q [NUM_SPRITES];
  logic                   pv_q;

  assign dx = {1'b0, DrawX};
  assign dy = {1'b0, DrawY};

  // One extra bit on the bounds keeps sprites at the right/bottom edge from wrapping to 0.
  always_comb begin
    cover_d = '0;
    offx_d  = '{default: '0};
    offy_d  = '{default: '0};
    for (int i = 0; i < NUM_SPRITES; i++) begin
      cover_d[i] = pix_valid & act_vis[i]
                 & (dx >= {1'b0, act_x[i]}) & (dx < ({1'b0, act_x[i]} + SIDE))
                 & (dy >= {1'b0, act_y[i]}) & (dy < ({1'b0, act_y[i]} + SIDE));
      offx_d[i]  = SIZE_LOG2'(DrawX - act_x[i]);
      offy_d[i]  = SIZE_LOG2'(DrawY - act_y[i]);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cover_q <= '0;
      pv_q    <= 1'b0;
      offx_q  <= '{default: '0};
      offy_q  <= '{default: '0};
    end else begin
      cover_q <= cover_d;
      pv_q    <= pix_valid;
      offx_q  <= offx_d;
      offy_q  <= offy_d;
    end
  end

  logic                 hit_d;
  logic [IDX_W-1:0]     idx_d;
  logic [SIZE_LOG2-1:0] lx_d;
  logic [SIZE_LOG2-1:0] ly_d;

  // Scanning downward lets the lowest covering index win.
  always_comb begin
    hit_d = |cover_q;
    idx_d = '0;
    lx_d  = '0;
    ly_d  = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (cover_q[i]) begin
        idx_d = IDX_W'(i);
        lx_d  = offx_q[i];
        ly_d  = offy_q[i];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      local_x   <= '0;
      local_y   <= '0;
    end else begin
      out_valid <= pv_q;
      hit       <= hit_d;
      hit_idx   <= idx_d;
      local_x   <= lx_d;
      local_y   <= ly_d;
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:1] acc;
  logic [NUM_SPRITES-1:1] acc_hit;

  assign acc_hit = cover_q[NUM_SPRITES-1:1] & {(NUM_SPRITES-1){cover_q[0]}};

  // Coverage seen in the swap cycle seeds the new frame rather than being lost.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc            <= '0;
      collision_mask <= '0;
    end else if (swap) begin
      collision_mask <= {acc, 1'b0};
      acc            <= acc_hit;
    end else begin
      acc <= acc | acc_hit;
    end
  end
`else
  assign collision_mask = '0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Table-driven scoreboard bench for sprite_compositor (NUM_SPRITES=8, COORD_W=10, SIZE_LOG2=4).
module tb_sprite_compositor;

  localparam int N  = 8;
  localparam int CW = 10;
  localparam int SL = 4;
  localparam int IW = 3;
`ifdef SPRITE_COLLISION_EN
  localparam int EXP_COLL = 32'h20;
`else
  localparam int EXP_COLL = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [CW-1:0] wr_x;
  logic [CW-1:0] wr_y;
  logic          wr_vis;
  logic          vs;
  logic          pix_valid;
  logic [CW-1:0] draw_x;
  logic [CW-1:0] draw_y;
  logic          out_valid;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [SL-1:0] local_x;
  logic [SL-1:0] local_y;
  logic [N-1:0]  collision_mask;

  sprite_compositor #(.NUM_SPRITES(N), .COORD_W(CW), .SIZE_LOG2(SL), .IDX_W(IW)) dut (
    .Clk(clk), .Reset(reset),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y), .wr_vis(wr_vis),
    .vs(vs), .pix_valid(pix_valid), .DrawX(draw_x), .DrawY(draw_y),
    .out_valid(out_valid), .hit(hit), .hit_idx(hit_idx),
    .local_x(local_x), .local_y(local_y), .collision_mask(collision_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks   = 0;
  int failures = 0;
  bit mon_on   = 1'b0;

  typedef struct {
    int phase; int x; int y; int hit; int idx; int lx; int ly;
  } vec_t;

  typedef struct {
    int due; int x; int y; int hit; int idx; int lx; int ly;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  exp_t e;

  task automatic checkOutput(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Expected pixels are popped when their 2-cycle latency elapses; otherwise out_valid must be low.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      checkOutput($sformatf("out_valid(%0d,%0d)", e.x, e.y), int'(out_valid), 1);
      checkOutput($sformatf("hit(%0d,%0d)", e.x, e.y), int'(hit), e.hit);
      checkOutput($sformatf("hit_idx(%0d,%0d)", e.x, e.y), int'(hit_idx), e.idx);
      checkOutput($sformatf("local_x(%0d,%0d)", e.x, e.y), int'(local_x), e.lx);
      checkOutput($sformatf("local_y(%0d,%0d)", e.x, e.y), int'(local_y), e.ly);
    end else if (mon_on) begin
      checkOutput("idle_out_valid", int'(out_valid), 0);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input int p, input int x, input int y, input int h,
                        input int i, input int lx, input int ly);
    vec_t v;
    v = '{p, x, y, h, i, lx, ly};
    tbl.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    exp_t x;
    draw_x    = CW'(v.x);
    draw_y    = CW'(v.y);
    pix_valid = 1'b1;
    x = '{cyc + 2, v.x, v.y, v.hit, v.idx, v.lx, v.ly};
    sb.push_back(x);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic runPhase(input int p);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].phase == p) applyStimulus(tbl[i]);
  endtask

  task automatic writeSlot(input int idx, input int x, input int y, input int vis);
    wr_en  = 1'b1;
    wr_idx = IW'(idx);
    wr_x   = CW'(x);
    wr_y   = CW'(y);
    wr_vis = vis[0];
    tick();
    wr_en = 1'b0;
  endtask

  task automatic frameSwap();
    vs = 1'b0;
    tick();
    vs = 1'b1;
    tick();
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  initial begin
    // phase, x, y, hit, idx, local_x, local_y
    addVec(0, 105,  55, 0, 0,  0,  0);
    addVec(1, 105,  55, 1, 2,  5,  5);
    addVec(2, 307, 301, 1, 1,  7,  1);
    addVec(2, 105,  55, 1, 2,  5,  5);
    addVec(2, 315, 315, 1, 1, 15, 15);
    addVec(2, 316, 300, 0, 0,  0,  0);
    addVec(3, 307, 301, 1, 3,  7,  1);
    addVec(4, 115, 100, 1, 0, 15,  0);
    addVec(4, 116, 100, 0, 0,  0,  0);
    addVec(4, 1023,  0, 1, 4,  8,  0);
    addVec(4,   0,   0, 0, 0,  0,  0);
    addVec(4, 1015, 15, 1, 4,  0, 15);
    addVec(4, 1023, 16, 0, 0,  0,  0);
    addVec(4, 100, 115, 1, 0,  0, 15);
    addVec(4,  99, 100, 0, 0,  0,  0);
    addVec(5, 505, 405, 0, 0,  0,  0);
    addVec(6, 505, 405, 1, 6,  5,  5);
    addVec(7, 210, 210, 1, 0, 10, 10);
    addVec(7, 209, 215, 1, 0,  9, 15);
    addVec(7, 216, 210, 1, 5,  8,  2);
    addVec(8, 210, 210, 1, 0, 10, 10);
    addVec(9, 210, 210, 1, 0, 10, 10);
    addVec(10, 210, 210, 0, 0, 0,  0);
    addVec(11, 210, 210, 0, 0, 0,  0);
    addVec(11, 105,  55, 0, 0, 0,  0);
    addVec(12, 210, 210, 1, 0, 10, 10);

    reset = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_vis = 1'b0;
    vs = 1'b1; pix_valid = 1'b0; draw_x = '0; draw_y = '0;
    repeat (3) tick();
    @(negedge clk);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_hit", int'(hit), 0);
    checkOutput("rst_hit_idx", int'(hit_idx), 0);
    checkOutput("rst_local_x", int'(local_x), 0);
    checkOutput("rst_local_y", int'(local_y), 0);
    checkOutput("rst_collision_mask", int'(collision_mask), 0);
    reset  = 1'b0;
    mon_on = 1'b1;
    tick();

    writeSlot(2, 100, 50, 1);
    runPhase(0);
    frameSwap();
    runPhase(1);

    writeSlot(1, 300, 300, 1);
    writeSlot(3, 300, 300, 1);
    frameSwap();
    runPhase(2);
    writeSlot(1, 300, 300, 0);
    frameSwap();
    runPhase(3);

    writeSlot(0, 100, 100, 1);
    writeSlot(4, 1015, 0, 1);
    frameSwap();
    runPhase(4);

    // Write landing in the exact swap cycle must wait one more frame.
    vs = 1'b0;
    writeSlot(6, 500, 400, 1);
    vs = 1'b1;
    tick();
    runPhase(5);
    frameSwap();
    runPhase(6);

    writeSlot(0, 200, 200, 1);
    writeSlot(5, 208, 208, 1);
    frameSwap();
    runPhase(7);
    drain();
    frameSwap();
    @(negedge clk);
    checkOutput("collision_mask_overlap", int'(collision_mask), EXP_COLL);
    tick();
    writeSlot(5, 600, 600, 1);
    frameSwap();
    runPhase(8);
    drain();
    frameSwap();
    @(negedge clk);
    checkOutput("collision_mask_apart", int'(collision_mask), 0);
    tick();

    // Mid-frame reset with a pixel in flight.
    runPhase(9);
    draw_x = CW'(210); draw_y = CW'(210); pix_valid = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_hit", int'(hit), 0);
    checkOutput("midrst_hit_idx", int'(hit_idx), 0);
    checkOutput("midrst_local_x", int'(local_x), 0);
    checkOutput("midrst_local_y", int'(local_y), 0);
    checkOutput("midrst_collision_mask", int'(collision_mask), 0);
    reset = 1'b0;
    pix_valid = 1'b0;
    tick();
    runPhase(10);
    frameSwap();
    runPhase(11);
    writeSlot(0, 200, 200, 1);
    frameSwap();
    runPhase(12);

    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    checkOutput("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
